// File: rtl/regfile_arbiter.sv
// Register file front-end: arbitrates three requesters onto one write/ext port
// and one read port, with hazard blocking, legality checks and fixed-latency read return.

module regfile_arbiter_dec (
  input  logic [1:0] op_i,
  input  logic [1:0] ext_i,
  input  logic [4:0] sel_i,
  output logic       legal_o,
  output logic       rd_o,
  output logic [4:0] lo_o,
  output logic [4:0] hi_o
);
  logic pair;

  always_comb begin
    rd_o    = (op_i == 2'b00);
    pair    = sel_i[4] | (op_i == 2'b10);
    lo_o    = {1'b0, sel_i[3:0]};
    hi_o    = lo_o + {4'b0000, pair};
    legal_o = 1'b0;
    case (op_i)
      2'b00, 2'b01: legal_o = sel_i[4] ? (sel_i[3:0] <= 4'd10) : (sel_i[3:0] <= 4'd11);
      2'b10:        legal_o = (ext_i != 2'b00) && (sel_i[3:0] <= 4'd10);
      default:      legal_o = 1'b0;
    endcase
  end
endmodule

module regfile_arbiter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  req_i,
  input  logic [5:0]  op_i,
  input  logic [5:0]  ext_i,
  input  logic [14:0] sel_i,
  input  logic [47:0] wdata_i,
  input  logic [15:0] rf_rdata_i,
  output logic [2:0]  gnt_o,
  output logic [2:0]  rd_valid_o,
  output logic [15:0] rd_data_o,
  output logic [2:0]  err_o,
  output logic        rf_write_en_o,
  output logic [15:0] rf_data_in_o,
  output logic [4:0]  rf_write_sel_o,
  output logic [4:0]  rf_read_sel_o,
  output logic [1:0]  rf_ext_op_o
);
  logic [2:0][1:0]  op_v, ext_v;
  logic [2:0][4:0]  sel_v, lo, hi;
  logic [2:0][15:0] wd_v;
  logic [2:0]       legal, is_rd;

  assign op_v  = op_i;
  assign ext_v = ext_i;
  assign sel_v = sel_i;
  assign wd_v  = wdata_i;

  for (genvar g = 0; g < 3; g++) begin : g_dec
    regfile_arbiter_dec u_dec (
      .op_i   (op_v[g]),
      .ext_i  (ext_v[g]),
      .sel_i  (sel_v[g]),
      .legal_o(legal[g]),
      .rd_o   (is_rd[g]),
      .lo_o   (lo[g]),
      .hi_o   (hi[g])
    );
  end

  // lead_q=0: requester 1 leads the round robin; 1: requester 2 leads
  logic        lead_q;
  logic [2:0]  gnt;
  logic        rd_take, wr_take, rd_lg, wr_lg;
  logic [1:0]  rd_id, wr_id, cur;
  logic [1:0]  ord [3];

  function automatic logic ovl(input logic [4:0] alo, ahi, blo, bhi);
    return (alo <= bhi) && (blo <= ahi);
  endfunction

  always_comb begin
    gnt     = 3'b000;
    rd_take = 1'b0;
    wr_take = 1'b0;
    rd_lg   = 1'b0;
    wr_lg   = 1'b0;
    rd_id   = 2'd0;
    wr_id   = 2'd0;
    cur     = 2'd0;
    ord[0]  = 2'd0;
    ord[1]  = lead_q ? 2'd2 : 2'd1;
    ord[2]  = lead_q ? 2'd1 : 2'd2;
    for (int k = 0; k < 3; k++) begin
      cur = ord[k];
      if (req_i[cur]) begin
        // Illegal requests occupy a slot but never conflict on register bytes
        if (is_rd[cur]) begin
          if (!rd_take && !(legal[cur] && wr_lg && ovl(lo[cur], hi[cur], lo[wr_id], hi[wr_id]))) begin
            gnt[cur] = 1'b1;
            rd_take  = 1'b1;
            rd_lg    = legal[cur];
            rd_id    = cur;
          end
        end else begin
          if (!wr_take && !(legal[cur] && rd_lg && ovl(lo[cur], hi[cur], lo[rd_id], hi[rd_id]))) begin
            gnt[cur] = 1'b1;
            wr_take  = 1'b1;
            wr_lg    = legal[cur];
            wr_id    = cur;
          end
        end
      end
    end
  end

  assign gnt_o = gnt;

  logic        wen_q, rpend_q;
  logic [1:0]  extop_q, rown_q;
  logic [4:0]  wsel_q, rsel_q;
  logic [15:0] wdat_q, rd_data_q;
  logic [2:0]  err_q, rd_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lead_q     <= 1'b0;
      wen_q      <= 1'b0;
      extop_q    <= 2'b00;
      wsel_q     <= 5'd0;
      wdat_q     <= 16'h0000;
      rsel_q     <= 5'd0;
      rpend_q    <= 1'b0;
      rown_q     <= 2'd0;
      err_q      <= 3'b000;
      rd_valid_q <= 3'b000;
      rd_data_q  <= 16'h0000;
    end else begin
      err_q   <= gnt & ~legal;
      wen_q   <= 1'b0;
      extop_q <= 2'b00;
      wsel_q  <= 5'd0;
      wdat_q  <= 16'h0000;
      if (wr_lg) begin
        if (op_v[wr_id] == 2'b01) begin
          wen_q  <= 1'b1;
          wsel_q <= sel_v[wr_id];
          wdat_q <= wd_v[wr_id];
        end else begin
          extop_q <= ext_v[wr_id];
          wsel_q  <= {1'b1, sel_v[wr_id][3:0]};
        end
      end
      rsel_q  <= rd_lg ? sel_v[rd_id] : 5'd0;
      rpend_q <= rd_lg;
      rown_q  <= rd_id;
      // Return stage: register file output sampled during the issue cycle
      rd_valid_q <= rpend_q ? (3'b001 << rown_q) : 3'b000;
      if (!rpend_q)       rd_data_q <= 16'h0000;
      else if (rsel_q[4]) rd_data_q <= rf_rdata_i;
      else                rd_data_q <= {8'h00, rf_rdata_i[7:0]};
      if (lead_q ? gnt[2] : gnt[1]) lead_q <= ~lead_q;
    end
  end

  assign rf_write_en_o  = wen_q;
  assign rf_ext_op_o    = extop_q;
  assign rf_write_sel_o = wsel_q;
  assign rf_data_in_o   = wdat_q;
  assign rf_read_sel_o  = rsel_q;
  assign err_o          = err_q;
  assign rd_valid_o     = rd_valid_q;
  assign rd_data_o      = rd_data_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: register file model, directed tables and sequences,
// and random traffic against an architectural reference model.

module tb_regfile_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  req;
  logic [5:0]  op, ext;
  logic [14:0] sel;
  logic [47:0] wdata;
  logic [15:0] rf_dout = 16'h0000;
  logic [2:0]  gnt, rd_valid, err;
  logic [15:0] rd_data, rf_data_in;
  logic        rf_write_en;
  logic [4:0]  rf_write_sel, rf_read_sel;
  logic [1:0]  rf_ext_op;

  regfile_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .ext_i(ext), .sel_i(sel),
    .wdata_i(wdata), .rf_rdata_i(rf_dout), .gnt_o(gnt), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .err_o(err), .rf_write_en_o(rf_write_en),
    .rf_data_in_o(rf_data_in), .rf_write_sel_o(rf_write_sel),
    .rf_read_sel_o(rf_read_sel), .rf_ext_op_o(rf_ext_op)
  );

  function automatic logic [15:0] ext_apply(input logic [15:0] v, input logic [1:0] e);
    case (e)
      2'b01:   return v + 16'd1;
      2'b10:   return v - 16'd1;
      2'b11:   return v + 16'd2;
      default: return v;
    endcase
  endfunction

  // Register file model: async read sampled mid-cycle, writes commit on the rising edge.
  // A single read drives junk on the upper byte so the arbiter's masking is visible.
  logic [7:0]  regs [12] = '{default: 8'h00};
  logic        cap_wen = 1'b0;
  logic [1:0]  cap_ext = 2'b00;
  logic [4:0]  cap_ws  = 5'd0;
  logic [15:0] cap_d   = 16'h0000;

  function automatic logic [15:0] rf_read(input logic [4:0] s);
    int i;
    i = int'(s[3:0]);
    if (s[4]) return (i <= 10) ? {regs[i], regs[i+1]} : 16'h0000;
    return (i <= 11) ? {~regs[i], regs[i]} : 16'h0000;
  endfunction

  always @(negedge clk) begin
    cap_wen <= rf_write_en;
    cap_ext <= rf_ext_op;
    cap_ws  <= rf_write_sel;
    cap_d   <= rf_data_in;
    rf_dout <= rf_read(rf_read_sel);
  end

  always @(posedge clk) begin
    if (cap_wen) begin
      if (cap_ws[4]) begin
        regs[cap_ws[3:0]]        <= cap_d[15:8];
        regs[cap_ws[3:0] + 4'd1] <= cap_d[7:0];
      end else begin
        regs[cap_ws[3:0]] <= cap_d[7:0];
      end
    end else if (cap_ext != 2'b00) begin
      {regs[cap_ws[3:0]], regs[cap_ws[3:0] + 4'd1]} <=
        ext_apply({regs[cap_ws[3:0]], regs[cap_ws[3:0] + 4'd1]}, cap_ext);
    end
  end

  // Reference model: architectural registers plus expected outputs one and two cycles ahead
  logic [7:0]  mreg [12] = '{default: 8'h00};
  int          lead;
  logic        a_wen;
  logic [1:0]  a_ext;
  logic [4:0]  a_ws, a_rs;
  logic [15:0] a_d, a_rd, b_rd;
  logic [2:0]  a_err, a_rv, b_rv;
  logic [2:0]  last_gnt;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic model_reset();
    lead = 1;
    a_wen = 0; a_ext = 0; a_ws = 0; a_rs = 0; a_d = 0; a_rd = 0; a_err = 0; a_rv = 0;
    b_rv = 0; b_rd = 0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] o, input logic [1:0] e, input logic [4:0] s);
    if (o == 2'b11) return 0;
    if (o == 2'b10) return (e != 2'b00) && (s[3:0] <= 10);
    return s[4] ? (s[3:0] <= 10) : (s[3:0] <= 11);
  endfunction

  function automatic logic [11:0] tmask(input logic [1:0] o, input logic [1:0] e, input logic [4:0] s);
    if (!is_legal(o, e, s)) return 12'h000;
    if (s[4] || o == 2'b10) return 12'h003 << s[3:0];
    return 12'h001 << s[3:0];
  endfunction

  function automatic logic [2:0] mgrant(input logic [2:0] rq, input logic [5:0] o, input logic [5:0] e,
                                        input logic [14:0] s, input int ld);
    int order [3];
    logic [2:0] g = 3'b000;
    bit rbusy = 0, wbusy = 0;
    logic [11:0] rm = 0, wm = 0, m;
    order = '{0, ld, 3 - ld};
    for (int k = 0; k < 3; k++) begin
      int i = order[k];
      if (rq[i]) begin
        m = tmask(o[2*i +: 2], e[2*i +: 2], s[5*i +: 5]);
        if (o[2*i +: 2] == 2'b00) begin
          if (!rbusy && (m & wm) == 0) begin g[i] = 1; rbusy = 1; rm = m; end
        end else begin
          if (!wbusy && (m & rm) == 0) begin g[i] = 1; wbusy = 1; wm = m; end
        end
      end
    end
    return g;
  endfunction

  task automatic model_accept(input logic [2:0] acc, input logic [5:0] o, input logic [5:0] e,
                              input logic [14:0] s, input logic [47:0] w);
    b_rv = a_rv; b_rd = a_rd;
    a_wen = 0; a_ext = 0; a_ws = 0; a_rs = 0; a_d = 0; a_rd = 0; a_err = 0; a_rv = 0;
    for (int i = 0; i < 3; i++) begin
      logic [4:0] si = s[5*i +: 5];
      int ix = int'(si[3:0]);
      if (acc[i] && !is_legal(o[2*i +: 2], e[2*i +: 2], si)) a_err[i] = 1;
      else if (acc[i] && o[2*i +: 2] == 2'b00) begin
        a_rv = 3'b001 << i;
        a_rs = si;
        a_rd = si[4] ? {mreg[ix], mreg[ix+1]} : {8'h00, mreg[ix]};
      end
    end
    for (int i = 0; i < 3; i++) begin
      logic [4:0]  si = s[5*i +: 5];
      logic [15:0] wi = w[16*i +: 16];
      int ix = int'(si[3:0]);
      if (acc[i] && is_legal(o[2*i +: 2], e[2*i +: 2], si) && o[2*i +: 2] != 2'b00) begin
        if (o[2*i +: 2] == 2'b01) begin
          a_wen = 1; a_ws = si; a_d = wi;
          if (si[4]) begin mreg[ix] = wi[15:8]; mreg[ix+1] = wi[7:0]; end
          else mreg[ix] = wi[7:0];
        end else begin
          a_ext = e[2*i +: 2]; a_ws = {1'b1, si[3:0]};
          {mreg[ix], mreg[ix+1]} = ext_apply({mreg[ix], mreg[ix+1]}, a_ext);
        end
      end
    end
    if (acc[lead]) lead = 3 - lead;
  endtask

  task automatic cycle(input logic [2:0] rq, input logic [5:0] o, input logic [5:0] e,
                       input logic [14:0] s, input logic [47:0] w);
    logic [2:0] mg;
    req = rq; op = o; ext = e; sel = s; wdata = w;
    @(negedge clk);
    mg = mgrant(rq, o, e, s, lead);
    last_gnt = gnt;
    chk("gnt", {13'd0, gnt}, {13'd0, mg});
    chk("err", {13'd0, err}, {13'd0, a_err});
    chk("rf_write_en", {15'd0, rf_write_en}, {15'd0, a_wen});
    chk("rf_ext_op", {14'd0, rf_ext_op}, {14'd0, a_ext});
    chk("rf_write_sel", {11'd0, rf_write_sel}, {11'd0, a_ws});
    chk("rf_data_in", rf_data_in, a_d);
    chk("rf_read_sel", {11'd0, rf_read_sel}, {11'd0, a_rs});
    chk("rd_valid", {13'd0, rd_valid}, {13'd0, b_rv});
    if (b_rv != 0) chk("rd_data", rd_data, b_rd);
    model_accept(mg, o, e, s, w);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(3'b000, 6'd0, 6'd0, 15'd0, 48'd0);
  endtask

  typedef struct {
    logic [2:0]  rq;
    logic [5:0]  o;
    logic [5:0]  e;
    logic [14:0] s;
    logic [47:0] w;
    logic [2:0]  g;
  } vec_t;

  vec_t tbl [11];

  initial begin
    req = 0; op = 0; ext = 0; sel = 0; wdata = 0;
    model_reset();

    // Round robin with writes from 1 and 2, one cycle of requester 0 interleaved
    tbl[0]  = '{3'b110, 6'b010101, 6'd0, {5'h18, 5'h14, 5'h10}, {16'h2222, 16'h1111, 16'h3333}, 3'b010};
    tbl[1]  = '{3'b110, 6'b010101, 6'd0, {5'h18, 5'h14, 5'h10}, {16'h2222, 16'h1111, 16'h3333}, 3'b100};
    tbl[2]  = '{3'b110, 6'b010101, 6'd0, {5'h18, 5'h14, 5'h10}, {16'h2222, 16'h1111, 16'h3333}, 3'b010};
    tbl[3]  = '{3'b110, 6'b010101, 6'd0, {5'h18, 5'h14, 5'h10}, {16'h2222, 16'h1111, 16'h3333}, 3'b100};
    tbl[4]  = '{3'b111, 6'b010101, 6'd0, {5'h18, 5'h14, 5'h10}, {16'h2222, 16'h1111, 16'h3333}, 3'b001};
    tbl[5]  = '{3'b110, 6'b010101, 6'd0, {5'h18, 5'h14, 5'h10}, {16'h2222, 16'h1111, 16'h3333}, 3'b010};
    tbl[6]  = '{3'b110, 6'b010101, 6'd0, {5'h18, 5'h14, 5'h10}, {16'h2222, 16'h1111, 16'h3333}, 3'b100};
    // Co-issue of EXT INC on {r10,r11} with reads, including an overlapping read that is deferred
    tbl[7]  = '{3'b101, 6'b000010, 6'b000001, {5'h02, 5'h00, 5'h0A}, 48'd0, 3'b101};
    tbl[8]  = '{3'b101, 6'b000010, 6'b000001, {5'h0B, 5'h00, 5'h0A}, 48'd0, 3'b001};
    tbl[9]  = '{3'b100, 6'b000000, 6'b000000, {5'h0B, 5'h00, 5'h00}, 48'd0, 3'b100};
    tbl[10] = '{3'b000, 6'b000000, 6'b000000, 15'd0, 48'd0, 3'b000};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", {13'd0, gnt}, 16'd0);
    chk("reset_rd_valid", {13'd0, rd_valid}, 16'd0);
    chk("reset_err", {13'd0, err}, 16'd0);
    chk("reset_rf", {rf_write_en, rf_ext_op, rf_write_sel, rf_read_sel}, 16'd0);
    rst_n = 1;

    for (int k = 0; k <= 6; k++) begin
      cycle(tbl[k].rq, tbl[k].o, tbl[k].e, tbl[k].s, tbl[k].w);
      chk("tbl_rr_gnt", {13'd0, last_gnt}, {13'd0, tbl[k].g});
    end

    // Write then read back the same pair
    cycle(3'b010, 6'b000100, 6'd0, {5'h00, 5'h12, 5'h00}, {16'h0, 16'hBEEF, 16'h0});
    cycle(3'b010, 6'b000000, 6'd0, {5'h00, 5'h12, 5'h00}, 48'd0);
    idle();
    chk("wr_rd_valid", {13'd0, rd_valid}, 16'h0002);
    chk("wr_rd_data", rd_data, 16'hBEEF);

    // {r10,r11} = 00FF, then the co-issue table
    cycle(3'b001, 6'b000001, 6'd0, {5'h00, 5'h00, 5'h1A}, {16'h0, 16'h0, 16'h00FF});
    idle();
    for (int k = 7; k <= 10; k++) begin
      cycle(tbl[k].rq, tbl[k].o, tbl[k].e, tbl[k].s, tbl[k].w);
      chk("tbl_co_gnt", {13'd0, last_gnt}, {13'd0, tbl[k].g});
    end
    chk("co_rd_valid", {13'd0, rd_valid}, 16'h0004);
    chk("co_rd_data", rd_data, 16'h0001);

    // Illegal pair read at index 11, then EXT with ext=00
    cycle(3'b010, 6'b000000, 6'd0, {5'h00, 5'h1B, 5'h00}, 48'd0);
    chk("ill_gnt", {13'd0, last_gnt}, 16'h0002);
    chk("ill_err", {13'd0, err}, 16'h0002);
    chk("ill_rf", {rf_write_en, rf_ext_op, rf_write_sel, rf_read_sel}, 16'd0);
    idle();
    chk("ill_rd_valid", {13'd0, rd_valid}, 16'd0);
    cycle(3'b100, 6'b100000, 6'd0, {5'h02, 5'h00, 5'h00}, 48'd0);
    chk("ill_ext_err", {13'd0, err}, 16'h0004);
    chk("ill_ext_rf", {rf_write_en, rf_ext_op, rf_write_sel, rf_read_sel}, 16'd0);
    idle();

    // Pair read, then single read with the upper byte masked
    cycle(3'b010, 6'b000100, 6'd0, {5'h00, 5'h16, 5'h00}, {16'h0, 16'hABCD, 16'h0});
    cycle(3'b010, 6'b000000, 6'd0, {5'h00, 5'h16, 5'h00}, 48'd0);
    idle();
    chk("pair_rd_data", rd_data, 16'hABCD);
    cycle(3'b010, 6'b000100, 6'd0, {5'h00, 5'h03, 5'h00}, {16'h0, 16'h005A, 16'h0});
    cycle(3'b010, 6'b000000, 6'd0, {5'h00, 5'h03, 5'h00}, 48'd0);
    idle();
    chk("single_rd_valid", {13'd0, rd_valid}, 16'h0002);
    chk("single_rd_data", rd_data, 16'h005A);

    // Reset while a read is in its issue cycle; leader returns to requester 1
    cycle(3'b100, 6'b010000, 6'd0, {5'h19, 5'h00, 5'h00}, {16'h4444, 32'h0});
    cycle(3'b010, 6'b000000, 6'd0, {5'h00, 5'h03, 5'h00}, 48'd0);
    req = 0; op = 0; ext = 0; sel = 0; wdata = 0;
    rst_n = 0;
    #1;
    chk("rst_rf", {rf_write_en, rf_ext_op, rf_write_sel, rf_read_sel}, 16'd0);
    chk("rst_data_in", rf_data_in, 16'd0);
    chk("rst_rd_valid0", {13'd0, rd_valid}, 16'd0);
    @(posedge clk); #1;
    chk("rst_rd_valid1", {13'd0, rd_valid}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    cycle(3'b110, 6'b010100, 6'd0, {5'h19, 5'h15, 5'h00}, {16'h5555, 16'h6666, 16'h0});
    chk("rst_first_gnt", {13'd0, last_gnt}, 16'h0002);
    idle();
    chk("rst_no_return", {13'd0, rd_valid}, 16'd0);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      cycle(3'($urandom), 6'($urandom), 6'($urandom), 15'($urandom),
            {16'($urandom), 32'($urandom)});
    end
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
